// File: rtl/stone_renderer_pkg.sv
// Shared game package: item-word field layout, item type codes, display
// colours and the renderer state encoding. The rope controllers decode the
// same item words, so field positions live here rather than in any one block.
package stone_renderer_pkg;

  // Item word field positions
  localparam int ITEM_X_MSB       = 31;
  localparam int ITEM_X_LSB       = 23;
  localparam int ITEM_Y_MSB       = 18;
  localparam int ITEM_Y_LSB       = 11;
  localparam int ITEM_TYPE_MSB    = 3;
  localparam int ITEM_TYPE_LSB    = 2;
  localparam int ITEM_VISIBLE_BIT = 1;
  localparam int ITEM_HOOKED_BIT  = 0;

  // Item type codes (2'b11 is drawn as a diamond too)
  localparam logic [1:0] TYPE_STONE   = 2'b00;
  localparam logic [1:0] TYPE_GOLD    = 2'b01;
  localparam logic [1:0] TYPE_DIAMOND = 2'b10;

  // Display colours
  localparam logic [2:0] COLOUR_STONE   = 3'b111;
  localparam logic [2:0] COLOUR_GOLD    = 3'b110;
  localparam logic [2:0] COLOUR_DIAMOND = 3'b011;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_ADDR,
    FETCH_WAIT,
    FETCH_LATCH,
    DECIDE,
    PLOT,
    NEXT,
    DONE
  } state_t;

  function automatic logic [2:0] typeColour(input logic [1:0] itemType);
    logic [2:0] c;
    case (itemType)
      TYPE_STONE: c = COLOUR_STONE;
      TYPE_GOLD:  c = COLOUR_GOLD;
      default:    c = COLOUR_DIAMOND;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/stone_renderer.sv
// Stone renderer: on a start request walks item slots 0..quantity-1, fetches
// each item word from the shared item RAM and, for visible items, draws a
// SPRITE x SPRITE square with its four corners knocked off, clipped to the
// screen.
// Ports:
//   clock, resetn          system clock, synchronous active-low reset
//   start                  single-cycle frame request (ignored while busy)
//   quantity[3:0]          number of item slots, sampled on accepted start
//   data[31:0]             item RAM read data, valid one clock after address
//   draw_stone_flag        RAM read-port ownership request (address = draw_index)
//   draw_index[3:0]        item slot currently being fetched/drawn
//   vga_x, vga_y, colour   pixel coordinates and colour
//   plot                   pixel write strobe
//   busy, done             render in progress / single-cycle completion pulse
module stone_renderer
  import stone_renderer_pkg::*;
#(
  parameter int SPRITE   = 16,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [3:0]  quantity,
  input  logic [31:0] data,
  output logic        draw_stone_flag,
  output logic [3:0]  draw_index,
  output logic [8:0]  vga_x,
  output logic [7:0]  vga_y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        busy,
  output logic        done
);

  localparam int            CW   = $clog2(SPRITE);
  localparam logic [CW-1:0] LAST = CW'(SPRITE - 1);
  localparam logic [9:0]    XLIM = 10'(SCREEN_W);
  localparam logic [8:0]    YLIM = 9'(SCREEN_H);

  state_t        r_state, w_next;
  logic [CW-1:0] r_row, r_col, w_nextRow, w_nextCol;
  logic [3:0]    r_quantity, r_index;
  logic [8:0]    r_itemX;
  logic [7:0]    r_itemY;
  logic [1:0]    r_itemType;
  logic          r_itemVisible;
  logic          r_flag, r_busy, r_done, r_plot;
  logic [8:0]    r_vgaX;
  logic [7:0]    r_vgaY;
  logic [2:0]    r_colour;
  logic [9:0]    w_sumX;
  logic [8:0]    w_sumY;
  logic          w_corner, w_pixOn, w_lastItem;
  logic          w_unusedData;

  // Bits of the item word this block has no use for (hooked does not
  // suppress drawing).
  assign w_unusedData = ^{data[22:19], data[10:4], data[ITEM_HOOKED_BIT]};

  assign w_lastItem = ({1'b0, r_index} + 5'd1) >= {1'b0, r_quantity};

  always_ff @(posedge clock) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Next state plus next sprite row/col; col runs fastest.
  always_comb begin
    w_next    = r_state;
    w_nextRow = r_row;
    w_nextCol = r_col;
    case (r_state)
      IDLE:        if (start) w_next = (quantity == 4'd0) ? DONE : FETCH_ADDR;
      FETCH_ADDR:  w_next = FETCH_WAIT;
      FETCH_WAIT:  w_next = FETCH_LATCH;
      FETCH_LATCH: w_next = DECIDE;
      DECIDE: begin
        if (r_itemVisible) begin
          w_next    = PLOT;
          w_nextRow = '0;
          w_nextCol = '0;
        end else begin
          w_next = NEXT;
        end
      end
      PLOT: begin
        if (r_col == LAST) begin
          w_nextCol = '0;
          if (r_row == LAST) begin
            w_next    = NEXT;
            w_nextCol = r_col;
          end else begin
            w_nextRow = r_row + 1'b1;
          end
        end else begin
          w_nextCol = r_col + 1'b1;
        end
      end
      NEXT:    w_next = w_lastItem ? DONE : FETCH_ADDR;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Pixel for the coordinates about to be registered; sums are kept one bit
  // wider than the screen coordinate so right/bottom overflow clips instead
  // of wrapping.
  always_comb begin
    w_sumX   = {1'b0, r_itemX} + {{(10 - CW){1'b0}}, w_nextCol};
    w_sumY   = {1'b0, r_itemY} + {{(9 - CW){1'b0}}, w_nextRow};
    w_corner = ((w_nextRow == '0) || (w_nextRow == LAST)) &&
               ((w_nextCol == '0) || (w_nextCol == LAST));
    w_pixOn  = (w_next == PLOT) && !w_corner && (w_sumX < XLIM) && (w_sumY < YLIM);
  end

  // Datapath and registered outputs, all derived from the next state so each
  // output lines up with the state it belongs to.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_row         <= '0;
      r_col         <= '0;
      r_quantity    <= '0;
      r_index       <= '0;
      r_itemX       <= '0;
      r_itemY       <= '0;
      r_itemType    <= '0;
      r_itemVisible <= 1'b0;
      r_flag        <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_plot        <= 1'b0;
      r_vgaX        <= '0;
      r_vgaY        <= '0;
      r_colour      <= '0;
    end else begin
      r_row <= w_nextRow;
      r_col <= w_nextCol;
      if (r_state == IDLE && start) begin
        r_quantity <= quantity;
        r_index    <= '0;
      end
      if (r_state == NEXT && !w_lastItem) r_index <= r_index + 4'd1;
      if (r_state == FETCH_LATCH) begin
        r_itemX       <= data[ITEM_X_MSB:ITEM_X_LSB];
        r_itemY       <= data[ITEM_Y_MSB:ITEM_Y_LSB];
        r_itemType    <= data[ITEM_TYPE_MSB:ITEM_TYPE_LSB];
        r_itemVisible <= data[ITEM_VISIBLE_BIT];
      end
      r_flag <= (w_next == FETCH_ADDR) || (w_next == FETCH_WAIT) || (w_next == FETCH_LATCH);
      r_busy <= (w_next != IDLE);
      r_done <= (w_next == DONE);
      r_plot <= w_pixOn;
      if (w_next == PLOT) begin
        r_vgaX   <= w_sumX[8:0];
        r_vgaY   <= w_sumY[7:0];
        r_colour <= typeColour(r_itemType);
      end
    end
  end

  assign draw_stone_flag = r_flag;
  assign draw_index      = r_index;
  assign vga_x           = r_vgaX;
  assign vga_y           = r_vgaY;
  assign colour          = r_colour;
  assign plot            = r_plot;
  assign busy            = r_busy;
  assign done            = r_done;

endmodule

// File: tb/tb_stone_renderer.sv
// Testbench for stone_renderer: table of frames with hand-computed latency,
// plot/fetch counts and first/last plotted pixel, plus hand-written
// sequences for reset mid-plot and start re-asserted while busy.
module tb_stone_renderer;

  logic        clock = 1'b0;
  logic        resetn, start;
  logic [3:0]  quantity;
  logic [31:0] data;
  logic        draw_stone_flag, plot, busy, done;
  logic [3:0]  draw_index;
  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  logic [2:0]  colour;

  stone_renderer dut (
    .clock(clock), .resetn(resetn), .start(start), .quantity(quantity), .data(data),
    .draw_stone_flag(draw_stone_flag), .draw_index(draw_index), .vga_x(vga_x),
    .vga_y(vga_y), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Item RAM: the renderer owns the address only while its flag is high;
  // otherwise another client reads and the bus carries unrelated data.
  logic [31:0] ram [16];
  always @(posedge clock) data <= draw_stone_flag ? ram[draw_index] : 32'hFFFF_FFFF;

  int nVectors = 0;
  int nFails   = 0;

  typedef struct {
    logic [3:0]       q;
    logic [3:0][31:0] items;
    int expLat, expPlots, expFlag, expMaxIdx;
    int expFirstX, expFirstY, expFirstC, expLastX, expLastY, expLastC;
  } vec_t;

  vec_t vecs [7];

  // Measured by runFrame
  int mLat, mPlots, mFlag, mMaxIdx, mFirstX, mFirstY, mFirstC, mLastX, mLastY, mLastC;
  int mFinished, mExtraDone, mBusyLow, mBusyAfter;

  function automatic logic [31:0] mkItem(input int x, input int y, input int t,
                                         input bit vis, input bit hooked);
    logic [31:0] w;
    logic [8:0]  xv;
    logic [7:0]  yv;
    logic [1:0]  tv;
    xv = x[8:0];
    yv = y[7:0];
    tv = t[1:0];
    w = 32'h0;
    w[31:23] = xv;
    w[18:11] = yv;
    w[3:2]   = tv;
    w[1]     = vis;
    w[0]     = hooked;
    return w;
  endfunction

  function automatic vec_t mkVec(input int q, input logic [31:0] i0, input logic [31:0] i1,
                                 input logic [31:0] i2, input logic [31:0] i3,
                                 input int lat, input int plots, input int flag, input int maxIdx,
                                 input int fx, input int fy, input int fc,
                                 input int lx, input int ly, input int lc);
    vec_t v;
    v.q = q[3:0];
    v.items[0] = i0; v.items[1] = i1; v.items[2] = i2; v.items[3] = i3;
    v.expLat = lat; v.expPlots = plots; v.expFlag = flag; v.expMaxIdx = maxIdx;
    v.expFirstX = fx; v.expFirstY = fy; v.expFirstC = fc;
    v.expLastX = lx; v.expLastY = ly; v.expLastC = lc;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    nVectors++;
    if (actual != expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Runs one frame; restartAt > 0 pulses start again that many cycles in.
  task automatic applyStimulus(input vec_t v, input int restartAt);
    bit first;
    for (int i = 0; i < 16; i++) ram[i] = (i < 4) ? v.items[i] : 32'h0;
    mLat = 0; mPlots = 0; mFlag = 0; mMaxIdx = 0; mFinished = 0;
    mFirstX = -1; mFirstY = -1; mFirstC = -1; mLastX = -1; mLastY = -1; mLastC = -1;
    mExtraDone = 0; mBusyLow = 0; mBusyAfter = 0;
    first = 1'b1;
    @(negedge clock);
    quantity = v.q;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start    = 1'b0;
    quantity = 4'hF;
    for (int e = 1; e <= 4000; e++) begin
      @(negedge clock);
      if (restartAt > 0 && e == restartAt)     start = 1'b1;
      if (restartAt > 0 && e == restartAt + 1) start = 1'b0;
      if (draw_stone_flag) mFlag++;
      if (!busy) mBusyLow++;
      if (int'(draw_index) > mMaxIdx) mMaxIdx = int'(draw_index);
      if (plot) begin
        mPlots++;
        if (first) begin
          mFirstX = int'(vga_x); mFirstY = int'(vga_y); mFirstC = int'(colour);
          first = 1'b0;
        end
        mLastX = int'(vga_x); mLastY = int'(vga_y); mLastC = int'(colour);
      end
      if (done) begin
        mLat = e + 1;
        mFinished = 1;
        break;
      end
    end
    start = 1'b0;
    for (int e = 0; e < 5; e++) begin
      @(negedge clock);
      if (done) mExtraDone++;
      if (busy) mBusyAfter++;
    end
  endtask

  task automatic checkFrame(input vec_t v, input string tag);
    checkOutput({tag, " finished"}, mFinished, 1);
    checkOutput({tag, " latency"}, mLat, v.expLat);
    checkOutput({tag, " plots"}, mPlots, v.expPlots);
    checkOutput({tag, " flagCycles"}, mFlag, v.expFlag);
    checkOutput({tag, " maxIndex"}, mMaxIdx, v.expMaxIdx);
    checkOutput({tag, " busyLowWhileRunning"}, mBusyLow, 0);
    checkOutput({tag, " extraDone"}, mExtraDone, 0);
    checkOutput({tag, " busyAfterDone"}, mBusyAfter, 0);
    if (v.expPlots > 0) begin
      checkOutput({tag, " firstX"}, mFirstX, v.expFirstX);
      checkOutput({tag, " firstY"}, mFirstY, v.expFirstY);
      checkOutput({tag, " firstColour"}, mFirstC, v.expFirstC);
      checkOutput({tag, " lastX"}, mLastX, v.expLastX);
      checkOutput({tag, " lastY"}, mLastY, v.expLastY);
      checkOutput({tag, " lastColour"}, mLastC, v.expLastC);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " flag"}, int'(draw_stone_flag), 0);
    checkOutput({tag, " index"}, int'(draw_index), 0);
    checkOutput({tag, " vga_x"}, int'(vga_x), 0);
    checkOutput({tag, " vga_y"}, int'(vga_y), 0);
    checkOutput({tag, " colour"}, int'(colour), 0);
    checkOutput({tag, " plot"}, int'(plot), 0);
    checkOutput({tag, " busy"}, int'(busy), 0);
    checkOutput({tag, " done"}, int'(done), 0);
  endtask

  initial begin
    int plotsSeen, doneSeen;
    resetn   = 1'b0;
    start    = 1'b0;
    quantity = 4'd0;
    for (int i = 0; i < 16; i++) ram[i] = 32'h0;

    // quantity, slots 0..3, latency, plots, flag cycles, max index,
    // first x/y/colour, last x/y/colour
    vecs[0] = mkVec(0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1] = mkVec(1, mkItem(100, 50, 1, 1, 0), 0, 0, 0,
                    263, 252, 3, 0, 101, 50, 6, 114, 65, 6);
    vecs[2] = mkVec(3, mkItem(20, 30, 0, 1, 0), mkItem(200, 100, 2, 0, 0),
                    mkItem(40, 60, 3, 1, 1), 0,
                    529, 504, 9, 2, 21, 30, 7, 54, 75, 3);
    vecs[3] = mkVec(1, mkItem(310, 230, 2, 1, 0), 0, 0, 0,
                    263, 99, 3, 0, 311, 230, 3, 319, 239, 3);
    vecs[4] = mkVec(2, mkItem(50, 50, 1, 0, 1), mkItem(60, 70, 2, 0, 0), 0, 0,
                    12, 0, 6, 1, 0, 0, 0, 0, 0, 0);
    vecs[5] = mkVec(15, 0, 0, 0, 0, 77, 0, 45, 14, 0, 0, 0, 0, 0, 0);
    vecs[6] = mkVec(1, mkItem(0, 235, 1, 1, 1), 0, 0, 0,
                    263, 78, 3, 0, 1, 235, 6, 15, 239, 6);

    repeat (3) @(posedge clock);
    #1;
    checkIdleOutputs("reset");
    resetn = 1'b1;
    repeat (2) @(posedge clock);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i], 0);
      checkFrame(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset asserted on the 100th plotted pixel, then a clean re-render
    for (int i = 0; i < 16; i++) ram[i] = (i < 4) ? vecs[1].items[i] : 32'h0;
    @(negedge clock);
    quantity = 4'd1;
    start    = 1'b1;
    @(negedge clock);
    start     = 1'b0;
    plotsSeen = 0;
    doneSeen  = 0;
    for (int e = 0; e < 1000; e++) begin
      if (plot) plotsSeen++;
      if (done) doneSeen++;
      if (plotsSeen == 100) break;
      @(negedge clock);
    end
    checkOutput("midReset reachedPlot100", plotsSeen, 100);
    resetn = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("midReset plot", int'(plot), 0);
    checkOutput("midReset flag", int'(draw_stone_flag), 0);
    checkOutput("midReset busy", int'(busy), 0);
    for (int e = 0; e < 3; e++) begin
      @(negedge clock);
      if (done) doneSeen++;
    end
    resetn = 1'b1;
    @(negedge clock);
    if (done) doneSeen++;
    checkOutput("midReset doneCount", doneSeen, 0);
    checkIdleOutputs("afterReset");
    applyStimulus(vecs[1], 0);
    checkFrame(vecs[1], "rerender");

    // Start pulsed again mid-PLOT must be ignored
    applyStimulus(vecs[1], 50);
    checkFrame(vecs[1], "restartIgnored");

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nFails);
    $finish;
  end

endmodule

// File: doc/stone_renderer.md
STONE_RENDERER -- requirements
Module: stone_renderer

Interface
REQ-001 Parameters SHALL be: SPRITE=16 (item edge in pixels), SCREEN_W=320, SCREEN_H=240.
REQ-002 Ports SHALL be (name direction width meaning): clock in 1 system clock; resetn in 1 reset, synchronous, active-low.
REQ-003 start in 1: single-cycle frame-render request.
REQ-004 quantity in 4: number of item slots (indices 0..quantity-1), sampled at accepted start.
REQ-005 data in 32: item RAM read port q; valid one clock after address.
REQ-006 draw_stone_flag out 1: RAM read-port ownership request; owner forces RAM address to draw_index while high.
REQ-007 draw_index out 4: item slot being fetched.
REQ-008 vga_x out 9, vga_y out 8, colour out 3, plot out 1: pixel write strobe and coordinates/colour.
REQ-009 busy out 1: render in progress; done out 1: single-cycle completion pulse.

Function
REQ-010 Item word SHALL decode as: X=data[31:23], Y=data[18:11], type=data[3:2], visible=data[1], hooked=data[0]; other bits ignored.
REQ-011 FSM states SHALL be IDLE, FETCH_ADDR, FETCH_WAIT, FETCH_LATCH, DECIDE, PLOT, NEXT, DONE.
REQ-012 IDLE: start=1 latches quantity, clears index to 0, goes to FETCH_ADDR (or DONE if quantity=0); start while busy SHALL be ignored.
REQ-013 draw_stone_flag SHALL be high in exactly FETCH_ADDR, FETCH_WAIT, FETCH_LATCH (3 cycles per item) and low in all other states.
REQ-014 FETCH_LATCH SHALL register data into an internal item register; no RAM data used outside that capture.
REQ-015 DECIDE: visible=0 -> NEXT; visible=1 -> clear row/col counters, go to PLOT; hooked does not suppress drawing.
REQ-016 PLOT SHALL emit one pixel per cycle, col fastest, row 0..15 then col 0..15 -> 256 cycles; vga_x=X+col, vga_y=Y+row.
REQ-017 plot SHALL be 0 for corner pixels (row,col) in {0,15}x{0,15} and for any pixel with X+col >= 320 or Y+row >= 240; sums computed at 10/9 bits, no wrap.
REQ-018 colour SHALL be 3'b111-based lookup: type 00 -> 3'b111 (stone), 01 -> 3'b110 (gold), 10/11 -> 3'b011 (diamond).
REQ-019 After row=15,col=15 FSM SHALL go to NEXT; NEXT increments index, goes to FETCH_ADDR if index<quantity else DONE.
REQ-020 DONE SHALL pulse done for one cycle, clear busy, return to IDLE; total latency = 1 + 5*quantity + 256*(visible count) + 1 cycles.
REQ-021 busy SHALL be high from the cycle after accepted start through the DONE cycle inclusive.
REQ-022 draw_index SHALL hold the current index in all non-IDLE states; index never exceeds 14 (quantity max 15).

Reset
REQ-023 resetn=0 at a clock edge SHALL force IDLE and zero draw_stone_flag, draw_index, vga_x, vga_y, colour, plot, busy, done, internal counters and item register.
REQ-024 Reset mid-FETCH or mid-PLOT SHALL drop draw_stone_flag and plot on that same edge; no done pulse is generated.

Structure
REQ-025 Item-word field positions, type codes and colour codes SHALL live in a shared game package used also by the rope controllers.
REQ-026 No sub-module is required; colour lookup and clipping stay inline; single always block for state, registered outputs.

Verification
REQ-027 quantity=0, start -> done pulses 2 cycles later, draw_stone_flag never high, plot never high.
REQ-028 quantity=1, slot0 X=100,Y=50,type=01,visible -> flag high 3 cycles, 252 plots colour 3'b110, first plotted pixel (101,50), done after 263 cycles.
REQ-029 quantity=3, slot1 visible=0 -> slot1 fetched (flag 3 cycles), zero plots for slot1, slots 0/2 drawn.
REQ-030 slot X=310,Y=230, visible -> plots only for x<320,y<240 (10x10 minus corner (0,0) = 99 plots).
REQ-031 resetn low at plot 100 -> plot, flag, busy 0 next edge; new start re-renders from index 0.
REQ-032 start asserted again during PLOT -> ignored; exactly one done pulse.
